// File: rtl/dev_ram_arbiter_pkg.sv
// rtl/dev_ram_arbiter_pkg.sv - shared types and helpers for the RAM arbiter
package pkg_ram_arb;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int N_CLIENTS_MAX = 8;

    // Width of a client index; never narrower than one bit.
    function automatic int client_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dev_ram_arbiter_if.sv
// rtl/dev_ram_arbiter_if.sv - client and RAM-side bus of the RAM arbiter
interface dev_ram_arbiter_if #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
);
    logic [N_CLIENTS-1:0]        req;
    logic [N_CLIENTS-1:0]        we;
    logic [N_CLIENTS*ADDR_W-1:0] addr;
    logic [N_CLIENTS*DATA_W-1:0] wdata;
    logic [N_CLIENTS-1:0]        lock;
    logic [N_CLIENTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ack;

    // Environment view: clients and the RAM.
    modport master (
        output req, we, addr, wdata, lock, mem_rdata, mem_ack,
        input  ack, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  req, we, addr, wdata, lock, mem_rdata, mem_ack,
        output ack, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dev_ram_arbiter_picker.sv
// rtl/dev_ram_arbiter_picker.sv - round-robin pick of the next requester after last_i
module dev_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan from furthest to nearest so the first requester after last_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            int c;
            c = (int'(last_i) + k) % N;
            if (req_i[IW'(c)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dev_ram_arbiter.sv
// rtl/dev_ram_arbiter.sv - N-client round-robin arbiter for the single-port RAM (optional RAM_ARB_LOCK_EN)
module dev_ram_arbiter
    import pkg_ram_arb::*;
#(
    parameter  int N_CLIENTS = 4,
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 8,
    parameter  int LOCK_MAX  = 16,
    localparam int IDX_W     = client_idx_w(N_CLIENTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    dev_ram_arbiter_if.slave bus,
    output logic [IDX_W-1:0] grant_id_o,
    output logic             busy_o
);

    arb_state_t                             state_q, state_d;
    logic [IDX_W-1:0]                       grant_q, grant_d;
    logic [IDX_W-1:0]                       last_q, last_d;
    logic                                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]                      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]                      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]                      rdata_q, rdata_d;
    logic [N_CLIENTS-1:0][ADDR_W-1:0]       addr_a;
    logic [N_CLIENTS-1:0][DATA_W-1:0]       wdata_a;
    logic                                   pick_valid, sel_valid;
    logic [IDX_W-1:0]                       pick_idx, sel_idx;
    logic [N_CLIENTS-1:0]                   ack_vec;

    assign addr_a  = bus.addr;
    assign wdata_a = bus.wdata;

    dev_rr_picker #(.N(N_CLIENTS), .IW(IDX_W)) u_picker (
        .req_i   (bus.req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef RAM_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    logic           lock_q;
    logic [LCW-1:0] lock_cnt_q;
    logic           relock;

    // A lock only survives into the single IDLE cycle right after DONE.
    assign relock    = lock_q && bus.req[grant_q] && (int'(lock_cnt_q) < LOCK_MAX);
    assign sel_valid = relock || pick_valid;
    assign sel_idx   = relock ? grant_q : pick_idx;

    // Track the lock request and how many consecutive grants it has produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            lock_q <= (state_q == DONE) && bus.lock[grant_q];
            if (state_q == IDLE && sel_valid)
                lock_cnt_q <= relock ? lock_cnt_q + 1'b1 : LCW'(1);
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
    assign sel_valid   = pick_valid;
    assign sel_idx     = pick_idx;
`endif

    // Next-state: latch the winner in IDLE, wait for the RAM, pulse ack in DONE.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d     = sel_idx;
                    mem_we_d    = bus.we[sel_idx];
                    mem_addr_d  = addr_a[sel_idx];
                    mem_wdata_d = wdata_a[sel_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset is asynchronous so mem_req drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IDX_W'(N_CLIENTS - 1);
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // One-hot completion pulse to the granted client.
    always_comb begin
        ack_vec = '0;
        if (state_q == DONE)
            ack_vec[grant_q] = 1'b1;
    end

    assign bus.ack       = ack_vec;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign grant_id_o    = grant_q;
    assign busy_o        = (state_q == ISSUE);

endmodule

// File: tb/tb_dev_ram_arbiter.sv
// tb/tb_dev_ram_arbiter.sv - self-checking bench for dev_ram_arbiter
module tb_dev_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dev_ram_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [1:0] grant_id;
    logic       busy;

    dev_ram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    logic [N-1:0][AW-1:0] addr_a;
    logic [N-1:0][DW-1:0] wdata_a;
    assign bus.addr  = addr_a;
    assign bus.wdata = wdata_a;

    int checks = 0;
    int errors = 0;
    logic [7:0] ram [0:65535];
    logic [7:0] model_mem [0:65535];
    int ram_delay = 0;
    int wait_cnt = 0;
    int ack_total = 0;
    int last_g = 3;
    logic         cw [N];
    logic [15:0]  ca [N];
    logic [7:0]   cd [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model: acks after ram_delay extra mem_req cycles, writes on ack.
    always @(negedge clk) begin
        if (rst_n !== 1'b1 || bus.mem_req !== 1'b1) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else if (wait_cnt >= ram_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Every ack pulse must be one-hot.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ack !== '0) begin
            ack_total++;
            chk("ack_onehot", 32'($countones(bus.ack)), 32'd1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic drive(input int c, input logic r, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic l);
        cw[c] = w; ca[c] = a; cd[c] = d;
        bus.req[c[1:0]]  = r;
        bus.we[c[1:0]]   = w;
        bus.lock[c[1:0]] = l;
        addr_a[c[1:0]]   = a;
        wdata_a[c[1:0]]  = d;
    endtask

    function automatic int model_pick(input logic [3:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (pend[c[1:0]]) return c;
        end
        return -1;
    endfunction

    // Expected rdata for client c's access, applying writes to the model memory.
    function automatic logic [7:0] model_access(input int c);
        if (cw[c]) begin
            model_mem[ca[c]] = cd[c];
            return 8'h00;
        end
        return model_mem[ca[c]];
    endfunction

    task automatic wait_ack(output int idx, output logic [7:0] rd, output int gid,
                            output int mcyc, output logic ok);
        ok = 1'b0; idx = -1; rd = '0; gid = -1; mcyc = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (bus.mem_req) mcyc++;
            if (bus.ack !== '0) begin
                ok = 1'b1;
                for (int c = 0; c < N; c++) if (bus.ack[c]) idx = c;
                rd  = bus.rdata;
                gid = int'(grant_id);
            end
        end
        chk("ack_seen", 32'(ok), 32'd1);
    endtask

    // Service a batch of simultaneous requests, checking each grant against the model.
    task automatic serve(input logic [3:0] pend_in, input string tag);
        logic [3:0] pend;
        int idx, gid, mcyc, e;
        logic [7:0] rd, erd;
        logic ok;
        pend = pend_in;
        for (int n = 0; n < 8 && pend != 0; n++) begin
            wait_ack(idx, rd, gid, mcyc, ok);
            if (!ok) break;
            e   = model_pick(pend, last_g);
            erd = model_access(e);
            chk({tag, "_grant"}, 32'(idx), 32'(e));
            chk({tag, "_grant_id"}, 32'(gid), 32'(e));
            chk({tag, "_rdata"}, 32'(rd), 32'(erd));
            bus.req[idx[1:0]] = 1'b0;
            bus.req[e[1:0]]   = 1'b0;
            pend[e[1:0]]      = 1'b0;
            last_g            = e;
        end
    endtask

    task automatic run_one(input int c, input logic w, input logic [15:0] a, input logic [7:0] d,
                           input string tag, output int mcyc);
        logic stable, done;
        logic [7:0] erd;
        drive(c, 1'b1, w, a, d, 1'b0);
        stable = 1'b1; done = 1'b0; mcyc = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                mcyc++;
                if (bus.mem_addr !== a || bus.mem_we !== w || (w && bus.mem_wdata !== d)) stable = 1'b0;
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (bus.ack !== '0) begin
                done = 1'b1;
                erd  = model_access(c);
                chk({tag, "_ack"}, 32'(bus.ack), 32'(1 << c));
                chk({tag, "_grant_id"}, 32'(grant_id), 32'(c));
                chk({tag, "_rdata"}, 32'(bus.rdata), 32'(erd));
                bus.req[c[1:0]] = 1'b0;
                last_g = c;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_mem_stable"}, 32'(stable), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = '0; bus.lock = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_g = 3;
    endtask

    initial begin
        int mcyc, idx, gid, a0;
        logic [7:0] rd;
        logic ok;
        logic [3:0] mask;
        int exp_q[$];

        bus.req = '0; bus.we = '0; bus.lock = '0; addr_a = '0; wdata_a = '0;
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'($urandom);
            model_mem[a] = ram[a];
        end
        ram[16'h0010] = 8'hA5;
        model_mem[16'h0010] = 8'hA5;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        rst_n = 1'b1;
        last_g = 3;

        // Client 2 reads 0x0010, RAM acks one cycle after mem_req
        ram_delay = 1;
        run_one(2, 1'b0, 16'h0010, 8'h00, "t1", mcyc);
        chk("t1_mreq_cycles", 32'(mcyc), 32'd2);
        chk("t1_rdata_a5", 32'(bus.rdata), 32'hA5);

        // Client 1 writes 0x3C to 0x0100 with a 5-cycle RAM delay, then reads it back
        ram_delay = 5;
        run_one(1, 1'b1, 16'h0100, 8'h3C, "t3", mcyc);
        chk("t3_mreq_cycles", 32'(mcyc), 32'd6);
        ram_delay = 0;
        run_one(1, 1'b0, 16'h0100, 8'h00, "t3rd", mcyc);
        chk("t3rd_mreq_cycles", 32'(mcyc), 32'd1);

        // Client 3 drops req right after grant; still completes and is acked once
        ram_delay = 2;
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.mem_req) ok = 1'b1;
        end
        chk("t6_granted", 32'(ok), 32'd1);
        bus.req[3] = 1'b0;
        a0 = ack_total;
        wait_ack(idx, rd, gid, mcyc, ok);
        chk("t6_grant", 32'(idx), 32'd3);
        chk("t6_rdata", 32'(rd), 32'(model_access(3)));
        last_g = 3;
        repeat (5) @(negedge clk);
        chk("t6_single_ack", 32'(ack_total - a0), 32'd1);

        // Randomized batches against the round-robin model
        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            ram_delay = $urandom_range(0, 3);
            for (int c = 0; c < N; c++)
                if (mask[c]) drive(c, 1'b1, 1'($urandom), 16'($urandom_range(0, 31)), 8'($urandom), 1'b0);
            serve(mask, "rand");
        end

        // Lock: client 0 locked and holding, client 1 waiting
        do_reset();
        ram_delay = 0;
`ifdef RAM_ARB_LOCK_EN
        exp_q = '{0, 0, 0, 0, 1};
`else
        exp_q = '{0, 1, 0, 1};
`endif
        drive(0, 1'b1, 1'b0, 16'h0030, 8'h00, 1'b1);
        drive(1, 1'b1, 1'b0, 16'h0031, 8'h00, 1'b0);
        foreach (exp_q[n]) begin
            wait_ack(idx, rd, gid, mcyc, ok);
            chk($sformatf("t5_grant%0d", n), 32'(idx), 32'(exp_q[n]));
            if (n == exp_q.size() - 1) bus.req = '0;
        end
        bus.lock = '0;
        last_g = exp_q[exp_q.size() - 1];
        repeat (3) @(negedge clk);

        // All four clients hold req: rotation 0,1,2,3,0
        do_reset();
        for (int c = 0; c < N; c++) drive(c, 1'b1, 1'b0, 16'(16'h0040 + c), 8'h00, 1'b0);
        for (int n = 0; n < 5; n++) begin
            wait_ack(idx, rd, gid, mcyc, ok);
            chk($sformatf("t2_grant%0d", n), 32'(idx), 32'((last_g + 1) % N));
            chk($sformatf("t2_rdata%0d", n), 32'(rd), 32'(model_mem[16'h0040 + ((last_g + 1) % N)]));
            last_g = (last_g + 1) % N;
            if (n == 4) bus.req = '0;
        end
        repeat (3) @(negedge clk);

        // Reset during ISSUE: mem_req and busy drop at once, no ack, client 0 wins after
        ram_delay = 5;
        drive(1, 1'b1, 1'b0, 16'h0050, 8'h00, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.mem_req) ok = 1'b1;
        end
        chk("t4_in_issue", 32'(ok), 32'd1);
        @(negedge clk);
        a0 = ack_total;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("t4_busy_drop", 32'(busy), 32'd0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("t4_no_ack", 32'(ack_total), 32'(a0));
        rst_n = 1'b1;
        last_g = 3;
        ram_delay = 1;
        drive(0, 1'b1, 1'b0, 16'h0060, 8'h00, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0061, 8'h00, 1'b0);
        serve(4'b0011, "t4");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
